// File: rtl/cache_miss_sequencer_if.sv
// rtl/cache_miss_sequencer_if.sv - miss request, victim and bus-beat signals of the miss sequencer
interface cache_miss_sequencer_if #(
  parameter int NUMWAYS      = 4,
  parameter int BEATSPERLINE = 4
);
  localparam int BW = $clog2(BEATSPERLINE);

  logic               Miss;
  logic               StoreMiss;
  logic               FlushStage;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimDirty;
  logic               BusBeatAck;
  logic               BusErr;
  logic               LRUWriteEn;
  logic [NUMWAYS-1:0] SelWay;
  logic               BusWrite;
  logic               BusRead;
  logic [BW-1:0]      BeatIdx;
  logic               FillWriteEn;
  logic               SetValid;
  logic               SetDirty;
  logic               ClearDirty;
  logic               CacheStall;
  logic               MissDone;
  logic               MissErr;

  modport master (
    output Miss, StoreMiss, FlushStage, VictimWay, VictimDirty, BusBeatAck, BusErr,
    input  LRUWriteEn, SelWay, BusWrite, BusRead, BeatIdx, FillWriteEn,
           SetValid, SetDirty, ClearDirty, CacheStall, MissDone, MissErr
  );

  modport slave (
    input  Miss, StoreMiss, FlushStage, VictimWay, VictimDirty, BusBeatAck, BusErr,
    output LRUWriteEn, SelWay, BusWrite, BusRead, BeatIdx, FillWriteEn,
           SetValid, SetDirty, ClearDirty, CacheStall, MissDone, MissErr
  );
endinterface

// File: rtl/cache_miss_sequencer.sv
// rtl/cache_miss_sequencer.sv - cache miss FSM: optional write-back, line fill, tag/LRU update
module cache_miss_sequencer #(
  parameter int NUMWAYS      = 4,
  parameter int BEATSPERLINE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cache_miss_sequencer_if.slave  bus
);
  localparam int            BW        = $clog2(BEATSPERLINE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATSPERLINE - 1);

  typedef enum logic [1:0] {READY, WRITEBACK, FILL, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [NUMWAYS-1:0] sel_q, sel_d;
  logic               store_q, store_d;

  logic start, bus_write, bus_read, fill_we, set_valid, lru_we, miss_done, miss_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= READY;
      beat_q  <= '0;
      sel_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    sel_d     = sel_q;
    store_d   = store_q;
    start     = 1'b0;
    bus_write = 1'b0;
    bus_read  = 1'b0;
    fill_we   = 1'b0;
    set_valid = 1'b0;
    lru_we    = 1'b0;
    miss_done = 1'b0;
    miss_err  = 1'b0;
    case (state_q)
      READY: begin
        if (bus.Miss && !bus.FlushStage) begin
          start   = 1'b1;
          sel_d   = bus.VictimWay;
          store_d = bus.StoreMiss;
          beat_d  = '0;
          state_d = bus.VictimDirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus_write = 1'b1;
        if (bus.BusErr) begin
          miss_err = 1'b1;
          beat_d   = '0;
          state_d  = READY;
        end else if (bus.BusBeatAck) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) state_d = FILL;
        end
      end
      FILL: begin
        bus_read = 1'b1;
        // An erroring beat is never written into the data array, even if acked.
        if (bus.BusErr) begin
          miss_err = 1'b1;
          beat_d   = '0;
          state_d  = READY;
        end else if (bus.BusBeatAck) begin
          fill_we = 1'b1;
          beat_d  = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) state_d = UPDATE;
        end
      end
      UPDATE: begin
        set_valid = 1'b1;
        lru_we    = 1'b1;
        miss_done = 1'b1;
        state_d   = READY;
      end
      default: state_d = READY;
    endcase
  end

  // Every output is forced low while reset_n is held, whatever state is registered.
  assign bus.LRUWriteEn  = reset_n & lru_we;
  assign bus.SelWay      = reset_n ? sel_q : '0;
  assign bus.BusWrite    = reset_n & bus_write;
  assign bus.BusRead     = reset_n & bus_read;
  assign bus.BeatIdx     = reset_n ? beat_q : '0;
  assign bus.FillWriteEn = reset_n & fill_we;
  assign bus.SetValid    = reset_n & set_valid;
  assign bus.SetDirty    = reset_n & set_valid & store_q;
  assign bus.ClearDirty  = reset_n & set_valid & ~store_q;
  assign bus.CacheStall  = reset_n & (start | (state_q != READY));
  assign bus.MissDone    = reset_n & miss_done;
  assign bus.MissErr     = reset_n & miss_err;
endmodule
